my_blink_meter: RTL and testbench

MY_BLINK_METER -- requirements
Module: my_blink_meter

---
 rtl/my_blink_meter_pkg.sv | 20 ++
 rtl/my_edge_sync.sv | 29 ++
 rtl/my_blink_meter.sv | 115 +++++++++++
 tb/tb_my_blink_meter.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/my_blink_meter_pkg.sv
// Shared state encoding and default constants for the blink meter.
package my_blink_meter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MEAS = 2'd1,
    LOST = 2'd2
  } state_t;

  localparam int unsigned DEF_CLK_FREQ   = 100_000_000;
  localparam int unsigned DEF_TIMEOUT_SEC = 3;
  localparam int unsigned DEF_TOL        = 2;
  localparam int unsigned DEF_CNT_W      = 32;

  function automatic longint unsigned timeout_cycles(input longint unsigned freq,
                                                     input longint unsigned secs);
    return freq * secs;
  endfunction

endpackage

// File: rtl/my_edge_sync.sv
// Two-flop synchronizer, edge register and registered rise/fall strobes.
module my_edge_sync (
  input  logic CLK,
  input  logic RST,
  input  logic D,
  output logic RISE,
  output logic FALL
);

  logic s1, s2, s3;

  // Strobes are registered so a rise reaches the FSM a fixed 3 edges after sampling.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      s3   <= 1'b0;
      RISE <= 1'b0;
      FALL <= 1'b0;
    end else begin
      s1   <= D;
      s2   <= s1;
      s3   <= s2;
      RISE <= s2 & ~s3;
      FALL <= ~s2 & s3;
    end
  end

endmodule

// File: rtl/my_blink_meter.sv
// Measures period and high time of a slow blink signal, tracks lock and signal loss.
module my_blink_meter
  import my_blink_meter_pkg::*;
#(
  parameter int unsigned CLK_FREQ    = DEF_CLK_FREQ,
  parameter int unsigned TIMEOUT_SEC = DEF_TIMEOUT_SEC,
  parameter int unsigned TOL         = DEF_TOL,
  parameter int unsigned CNT_W       = DEF_CNT_W
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             SIG_IN,
  output logic [CNT_W-1:0] PERIOD,
  output logic [CNT_W-1:0] HIGH_TIME,
  output logic             VALID,
  output logic             LOCKED,
  output logic             TIMEOUT
);

  localparam longint unsigned TIMEOUT_CYC = timeout_cycles(CLK_FREQ, TIMEOUT_SEC);
  localparam logic [CNT_W-1:0] TO_CYC = CNT_W'(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] TOL_V  = CNT_W'(TOL);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

  generate
    if (CNT_W < 64 && TIMEOUT_CYC > ((64'd1 << CNT_W) - 64'd1)) begin : g_cnt_w_chk
      $error("my_blink_meter: CNT_W too small to hold CLK_FREQ*TIMEOUT_SEC");
    end
  endgenerate

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + ONE;
  endfunction

  function automatic logic [CNT_W-1:0] abs_diff(input logic [CNT_W-1:0] a,
                                                input logic [CNT_W-1:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  logic rise, fall;

  my_edge_sync u_sync (
    .CLK  (CLK),
    .RST  (RST),
    .D    (SIG_IN),
    .RISE (rise),
    .FALL (fall)
  );

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, hi_lat, prev_period;
  logic [1:0]       meas_cnt;
  logic             start, take, expire;

  always_ff @(posedge CLK) begin
    if (!RST) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (rise) state_nxt = MEAS;
      MEAS:    if (!rise && cnt == TO_CYC) state_nxt = LOST;
      LOST:    if (rise) state_nxt = MEAS;
      default: state_nxt = IDLE;
    endcase
  end

  // A rise in the timeout cycle wins, so expire only fires without one.
  always_comb begin
    start  = (state == IDLE || state == LOST) && rise;
    take   = (state == MEAS) && rise;
    expire = (state == MEAS) && !rise && (cnt == TO_CYC);
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      cnt         <= '0;
      hi_lat      <= '0;
      prev_period <= '0;
      meas_cnt    <= 2'd0;
      PERIOD      <= '0;
      HIGH_TIME   <= '0;
      VALID       <= 1'b0;
      LOCKED      <= 1'b0;
      TIMEOUT     <= 1'b0;
    end else begin
      VALID <= 1'b0;
      if (start) begin
        cnt      <= ONE;
        hi_lat   <= '0;
        meas_cnt <= 2'd0;
        TIMEOUT  <= 1'b0;
      end else if (take) begin
        PERIOD      <= cnt;
        HIGH_TIME   <= hi_lat;
        VALID       <= 1'b1;
        prev_period <= cnt;
        cnt         <= ONE;
        hi_lat      <= '0;
        LOCKED      <= (meas_cnt != 2'd0) && (abs_diff(cnt, prev_period) <= TOL_V);
        if (meas_cnt != 2'd2) meas_cnt <= meas_cnt + 2'd1;
      end else if (state == MEAS) begin
        cnt <= sat_inc(cnt);
        if (fall) hi_lat <= cnt;
        if (expire) begin
          TIMEOUT <= 1'b1;
          LOCKED  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_my_blink_meter.sv
// Directed bench for my_blink_meter with a fast (10 Hz) clock configuration.
`timescale 1ms/1ms
module tb_my_blink_meter;
  import my_blink_meter_pkg::*;

  logic        CLK, RST, SIG_IN;
  logic [31:0] PERIOD, HIGH_TIME;
  logic        VALID, LOCKED, TIMEOUT;

  int n_chk  = 0;
  int n_fail = 0;
  int nv     = 0;
  int n0     = 0;
  logic [31:0] lp = '0, lh = '0;
  logic        llk = 1'b0;

  my_blink_meter #(
    .CLK_FREQ    (10),
    .TIMEOUT_SEC (3),
    .TOL         (1),
    .CNT_W       (32)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .SIG_IN    (SIG_IN),
    .PERIOD    (PERIOD),
    .HIGH_TIME (HIGH_TIME),
    .VALID     (VALID),
    .LOCKED    (LOCKED),
    .TIMEOUT   (TIMEOUT)
  );

  initial CLK = 1'b0;
  always #50 CLK = ~CLK;

  always @(negedge CLK) begin
    if (VALID === 1'b1) begin
      nv  = nv + 1;
      lp  = PERIOD;
      lh  = HIGH_TIME;
      llk = LOCKED;
    end
  end

  initial begin
    #(100 * 5000);
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic pulse(input int hi, input int lo);
    SIG_IN = 1'b1;
    tick(hi);
    SIG_IN = 1'b0;
    tick(lo);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_period"},  PERIOD, 32'd0);
    chk({tag, "_high"},    HIGH_TIME, 32'd0);
    chk({tag, "_valid"},   32'(VALID), 32'd0);
    chk({tag, "_locked"},  32'(LOCKED), 32'd0);
    chk({tag, "_timeout"}, 32'(TIMEOUT), 32'd0);
    chk({tag, "_state"},   32'(dut.state), 32'(IDLE));
  endtask

  initial begin
    RST = 1'b0;
    SIG_IN = 1'b0;
    // Reset with the input toggling
    for (int i = 0; i < 5; i++) begin
      SIG_IN = ~SIG_IN;
      tick(1);
    end
    chk_zero("rst");
    chk("rst_nvalid", 32'(nv), 32'd0);
    SIG_IN = 1'b0;
    tick(2);
    RST = 1'b1;
    tick(3);
    chk("rel_nvalid", 32'(nv), 32'd0);

    // 10-cycle period, 5 high: first rise only starts counting
    pulse(5, 5);
    chk("first_rise_nvalid", 32'(nv), 32'd0);
    chk("first_rise_state", 32'(dut.state), 32'(MEAS));
    SIG_IN = 1'b1;
    tick(3);
    chk("lat_early_valid", 32'(VALID), 32'd0);
    tick(1);
    chk("lat_valid", 32'(VALID), 32'd1);
    chk("p10_period", PERIOD, 32'd10);
    chk("p10_high", HIGH_TIME, 32'd5);
    chk("p10_unlocked", 32'(LOCKED), 32'd0);
    tick(1);
    chk("valid_one_cycle", 32'(VALID), 32'd0);
    SIG_IN = 1'b0;
    tick(5);
    pulse(5, 5);
    chk("p10b_nvalid", 32'(nv), 32'd2);
    chk("p10b_period", lp, 32'd10);
    chk("p10b_locked", 32'(LOCKED), 32'd1);

    // Period change 10 -> 14
    pulse(5, 9);
    chk("p14a_prev_period", lp, 32'd10);
    pulse(5, 9);
    chk("p14_period", lp, 32'd14);
    chk("p14_lock_at_valid", 32'(llk), 32'd0);
    chk("p14_locked", 32'(LOCKED), 32'd0);
    pulse(5, 5);
    chk("p14b_period", lp, 32'd14);
    chk("p14b_high", lh, 32'd5);
    chk("p14b_locked", 32'(LOCKED), 32'd1);
    chk("p14b_nvalid", 32'(nv), 32'd5);

    // Back to 10, relock, then drop the signal
    pulse(5, 5);
    chk("p10c_unlocked", 32'(LOCKED), 32'd0);
    pulse(5, 5);
    chk("p10d_locked", 32'(LOCKED), 32'd1);
    SIG_IN = 1'b1;
    tick(5);
    SIG_IN = 1'b0;
    tick(28);
    chk("to_early", 32'(TIMEOUT), 32'd0);
    tick(1);
    chk("to_flag", 32'(TIMEOUT), 32'd1);
    chk("to_unlocked", 32'(LOCKED), 32'd0);
    chk("to_period_held", PERIOD, 32'd10);
    chk("to_high_held", HIGH_TIME, 32'd5);
    chk("to_state", 32'(dut.state), 32'(LOST));
    chk("to_nvalid", 32'(nv), 32'd8);

    // Recovery rise: leaves LOST without a VALID
    SIG_IN = 1'b1;
    tick(4);
    chk("rec_timeout", 32'(TIMEOUT), 32'd0);
    chk("rec_valid", 32'(VALID), 32'd0);
    chk("rec_state", 32'(dut.state), 32'(MEAS));
    tick(1);
    SIG_IN = 1'b0;
    tick(25);
    // Next rise lands exactly on cnt == 30
    SIG_IN = 1'b1;
    tick(3);
    chk("edge30_early", 32'(VALID), 32'd0);
    tick(1);
    chk("edge30_valid", 32'(VALID), 32'd1);
    chk("edge30_period", PERIOD, 32'd30);
    chk("edge30_high", HIGH_TIME, 32'd5);
    chk("edge30_timeout", 32'(TIMEOUT), 32'd0);
    chk("edge30_locked", 32'(LOCKED), 32'd0);
    chk("edge30_nvalid", 32'(nv), 32'd8);

    // Reset mid-measurement at cnt = 6
    tick(1);
    SIG_IN = 1'b0;
    tick(4);
    chk("mid_cnt", dut.cnt, 32'd6);
    RST = 1'b0;
    tick(1);
    chk_zero("midrst");
    RST = 1'b1;
    tick(3);
    n0 = nv;
    pulse(5, 5);
    chk("post_rst_first_nvalid", 32'(nv - n0), 32'd0);
    pulse(5, 5);
    chk("post_rst_nvalid", 32'(nv - n0), 32'd1);
    chk("post_rst_period", lp, 32'd10);
    chk("post_rst_high", lh, 32'd5);
    chk("post_rst_unlocked", 32'(LOCKED), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
